seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have a parameter DIGITS, default 4, giving the number of multiplexed digits (range 1..8).
REQ-002 The block SHALL have a parameter PRESCALE, default 100000, giving the clock cycles per digit slot (minimum 2).
REQ-003 The block SHALL have a parameter BLANK_LZ, default 1, which enables leading-zero blanking when 1.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port LOAD, input, 1 bit: a one-cycle strobe that captures VALUE and DP_IN.
REQ-007 The block SHALL have port VALUE, input, 4*DIGITS bits: hex nibbles, where digit i is VALUE[4i+3:4i] and digit 0 is rightmost.
REQ-008 The block SHALL have port DP_IN, input, DIGITS bits: the decimal-point request per digit.
REQ-009 The block SHALL have port EN, input, 1 bit: display enable; when 0, all anodes are off.
REQ-010 The block SHALL have ports CA, CB, CC, CD, CE, CF, CG, outputs, 1 bit each: active-low segment drives.
REQ-011 The block SHALL have port DP, output, 1 bit: active-low decimal point.
REQ-012 The block SHALL have port AN, output, DIGITS bits: active-low digit anodes, with at most one bit low.
REQ-013 The block SHALL have port FRAME, output, 1 bit: a one-cycle pulse at each frame commit.

Function
REQ-014 The prescaler SHALL count 0..PRESCALE-1 and wrap; TICK is asserted in the cycle the count equals PRESCALE-1.
REQ-015 On TICK, the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-016 A frame boundary SHALL be TICK while the index equals DIGITS-1.
REQ-017 LOAD SHALL write VALUE and DP_IN into a pending register; a later LOAD before the boundary overwrites it.
REQ-018 At a frame boundary, the display register SHALL take the pending contents; if LOAD occurs in the same cycle, it SHALL take VALUE/DP_IN directly.
REQ-019 FRAME SHALL pulse high for exactly one cycle, registered, in the cycle after each frame boundary.
REQ-020 All outputs SHALL be registered; CA..CG, DP and AN reflect the index and display register one cycle after they change.
REQ-021 Decode SHALL use CA..CG order, 0 = lit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 With BLANK_LZ=1, digit i>0 SHALL be blanked (segments 1111111) when it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-023 DP SHALL equal the inverse of the display DP bit of the active digit; DP is not blanked by REQ-022.
REQ-024 With EN=0, AN SHALL be all ones, and the prescaler, index, LOAD and commit SHALL keep running unchanged.
REQ-025 For the active index k with EN=1, AN[k] SHALL be 0 and all other AN bits SHALL be 1.

Reset
REQ-026 RST high SHALL immediately clear the prescaler, index, pending and display registers to 0 and FRAME to 0.
REQ-027 RST high SHALL immediately set CA..CG and DP to 1 and AN to all ones.
REQ-028 After RST deasserts, the first TICK SHALL occur PRESCALE cycles later, and the first commit SHALL occur after DIGITS*PRESCALE cycles.
REQ-029 RST during a scan SHALL discard pending data; no partial commit is permitted.

Structure
REQ-030 The 16-entry segment code table and segment-off constant SHALL reside in a shared package, sevenseg_pkg.
REQ-031 Decode SHALL be one combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out).
REQ-032 The prescaler, index, shadow registers and output registers SHALL reside in seven_seg_scan.

Verification (DIGITS=4, PRESCALE=4, BLANK_LZ=1)
REQ-033 Scenario 1: release RST and hold LOAD=0. Required: AN=1111 and segments=1111111 until the first TICK; afterwards AN cycles 1110, 1101, 1011, 0111, with digit 0 showing 0000001 and digits 1-3 blanked.
REQ-034 Scenario 2: LOAD VALUE=16'h3A0F, DP_IN=0010. Required: after the next boundary, FRAME pulses once; digit0=0111000, digit1=0000001 (not blanked), digit2=0001000, digit3=0000110; DP=0 only while AN=1101.
REQ-035 Scenario 3: LOAD 16'h0005 then 16'h0007 in the same frame. Required: only 0007 is displayed after the commit, and digits 1-3 are blanked.
REQ-036 Scenario 4: LOAD 16'h1234 in the exact boundary cycle. Required: it is committed at that boundary, and the next frame shows 1,2,3,4.
REQ-037 Scenario 5: EN=0 for 20 cycles mid-scan. Required: AN=1111 throughout; the index after re-enable matches the free-running count.
REQ-038 Scenario 6: assert RST mid-frame with a pending value. Required: all outputs go off asynchronously, and the pending value is never displayed.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low segment codes in CA..CG bit order
// (bit 6 = CA, bit 0 = CG) and the all-segments-off pattern.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: prescaled digit rotation, frame-synchronous
// commit of a pending value, leading-zero blanking and fully registered outputs.
module seven_seg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  EN,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic                   boundary;
  logic                   scan_on;

  logic [DIGITS-1:0][3:0] value_v;
  logic [DIGITS-1:0][3:0] pend_val;
  logic [DIGITS-1:0][3:0] disp_val;
  logic [DIGITS-1:0]      pend_dp;
  logic [DIGITS-1:0]      disp_dp;

  seg_t [DIGITS-1:0]      dec_seg;
  logic [DIGITS-1:0]      show;
  logic                   nz;

  seg_t                   seg_nxt;
  logic                   dp_nxt;
  logic [DIGITS-1:0]      an_nxt;

  seg_t                   seg_q;
  logic                   dp_q;
  logic [DIGITS-1:0]      an_q;
  logic                   frame_q;

  assign value_v  = VALUE;
  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Prescaler and digit index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      idx     <= '0;
      scan_on <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        scan_on <= 1'b1;
      end
    end
  end

  // Pending shadow; a LOAD in the boundary cycle bypasses it into the display.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (LOAD) begin
        pend_val <= value_v;
        pend_dp  <= DP_IN;
      end
      if (boundary) begin
        disp_val <= LOAD ? value_v : pend_val;
        disp_dp  <= LOAD ? DP_IN   : pend_dp;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    hex_to_seg u_dec (
      .nib (disp_val[g]),
      .seg (dec_seg[g])
    );
  end

  // Walk from the top digit down; a digit shows once any digit at or above it is nonzero.
  always_comb begin
    show = '0;
    nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz      = nz | (|disp_val[i]);
      show[i] = nz || (i == 0) || (BLANK_LZ == 0);
    end
  end

  // Outputs stay dark until the scan has made its first step after reset.
  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    an_nxt  = '1;
    if (scan_on) begin
      seg_nxt = show[idx] ? dec_seg[idx] : SEG_OFF;
      dp_nxt  = ~disp_dp[idx];
      if (EN)
        an_nxt = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      an_q    <= an_nxt;
      frame_q <= boundary;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP    = dp_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIGITS=4, PRESCALE=4, BLANK_LZ=1.
module tb_seven_seg_scan;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOAD;
  logic [15:0] VALUE;
  logic [3:0]  DP_IN;
  logic        EN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, FRAME;
  logic [3:0]  AN;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;

  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  always #5 CLK = ~CLK;

  seven_seg_scan #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .DP_IN(DP_IN), .EN(EN),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN), .FRAME(FRAME)
  );

  typedef struct {
    logic             pre;
    logic [15:0]      pre_val;
    logic [15:0]      val;
    logic [3:0]       dp;
    logic [3:0][6:0]  seg;   // expected {d3, d2, d1, d0}
    logic [3:0]       dpo;   // expected DP pin per digit
  } vec_t;

  localparam logic [6:0] OFF = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    LOAD  = 1'b1;
    VALUE = v;
    DP_IN = d;
    @(negedge CLK);
    LOAD  = 1'b0;
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (FRAME !== 1'b1 && k < 40);
    chk("frame_wait", {31'd0, FRAME}, 32'd1);
  endtask

  // Entered at the negedge where digit 0 is on; digits change every 4 cycles.
  task automatic check_digits(input string tag, input vec_t v);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] an_exp;
      an_exp = ~(4'b0001 << k);
      chk($sformatf("%s_an%0d", tag, k), {28'd0, AN}, {28'd0, an_exp});
      chk($sformatf("%s_seg%0d", tag, k), {25'd0, seg}, {25'd0, v.seg[k]});
      chk($sformatf("%s_dp%0d", tag, k), {31'd0, DP}, {31'd0, v.dpo[k]});
      if (k < 3) repeat (4) @(negedge CLK);
    end
  endtask

  vec_t vecs[5];
  vec_t v1234;
  vec_t vzero;

  initial begin
    int l;
    int k;

    vecs[0] = '{1'b0, 16'h0000, 16'h3A0F, 4'b0010,
                {7'b0000110, 7'b0001000, 7'b0000001, 7'b0111000}, 4'b1101};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 4'b0000,
                {OFF, OFF, OFF, 7'b0001111}, 4'b1111};
    vecs[2] = '{1'b0, 16'h0000, 16'h00B0, 4'b1001,
                {OFF, OFF, 7'b1100000, 7'b0000001}, 4'b0110};
    vecs[3] = '{1'b0, 16'h0000, 16'h8E6C, 4'b0100,
                {7'b0000000, 7'b0110000, 7'b0100000, 7'b0110001}, 4'b1011};
    vecs[4] = '{1'b0, 16'h0000, 16'h0D95, 4'b1111,
                {OFF, 7'b1000010, 7'b0000100, 7'b0100100}, 4'b0000};
    v1234   = '{1'b0, 16'h0000, 16'h1234, 4'b0000,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
    vzero   = '{1'b0, 16'h0000, 16'h0000, 4'b0000,
                {OFF, OFF, OFF, 7'b0000001}, 4'b1111};

    RST = 1'b1; LOAD = 1'b0; VALUE = '0; DP_IN = '0; EN = 1'b1;
    #1;
    chk("rst_an", {28'd0, AN}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, DP}, 32'd1);
    chk("rst_frame", {31'd0, FRAME}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Scenario 1: dark until the first tick, then scan a blanked zero.
    for (int c = 1; c <= 17; c++) begin
      @(negedge CLK);
      if (c <= 4) begin
        chk($sformatf("s1_an_c%0d", c), {28'd0, AN}, 32'hF);
        chk($sformatf("s1_seg_c%0d", c), {25'd0, seg}, 32'h7F);
      end
      if (c == 5)  chk("s1_an_d1", {28'd0, AN}, 32'hD);
      if (c == 9)  chk("s1_an_d2", {28'd0, AN}, 32'hB);
      if (c == 13) chk("s1_an_d3", {28'd0, AN}, 32'h7);
      if (c == 5 || c == 9 || c == 13)
        chk($sformatf("s1_blank_c%0d", c), {25'd0, seg}, 32'h7F);
      if (c == 15) chk("s1_frame_lo", {31'd0, FRAME}, 32'd0);
      if (c == 16) chk("s1_frame_hi", {31'd0, FRAME}, 32'd1);
      if (c == 17) begin
        chk("s1_frame_once", {31'd0, FRAME}, 32'd0);
        chk("s1_an_d0", {28'd0, AN}, 32'hE);
        chk("s1_seg_d0", {25'd0, seg}, {25'd0, 7'b0000001});
        chk("s1_dp_d0", {31'd0, DP}, 32'd1);
      end
    end

    // Table: each frame loads the next vector, then checks the one on display.
    load(vecs[0].val, vecs[0].dp);
    wait_frame();
    for (int i = 0; i < 5; i++) begin
      l = 0;
      if (i + 1 < 5) begin
        if (vecs[i+1].pre) begin
          load(vecs[i+1].pre_val, 4'b0000);
          l++;
        end
        load(vecs[i+1].val, vecs[i+1].dp);
        l++;
      end
      repeat (2 - l) @(negedge CLK);
      check_digits($sformatf("v%0d", i), vecs[i]);
      wait_frame();
    end

    // Scenario 4: LOAD in the exact boundary cycle goes straight to the display.
    repeat (15) @(negedge CLK);
    LOAD = 1'b1; VALUE = v1234.val; DP_IN = v1234.dp;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("s4_frame", {31'd0, FRAME}, 32'd1);
    repeat (2) @(negedge CLK);
    check_digits("s4", v1234);

    // Scenario 5: anodes off while disabled; scan position keeps advancing.
    EN = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      chk($sformatf("s5_off_c%0d", c), {28'd0, AN}, 32'hF);
    end
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("s5_an_a", {28'd0, AN}, 32'hE);
    chk("s5_seg_a", {25'd0, seg}, {25'd0, 7'b1001100});
    repeat (4) @(negedge CLK);
    chk("s5_an_b", {28'd0, AN}, 32'hD);
    chk("s5_seg_b", {25'd0, seg}, {25'd0, 7'b0000110});

    // Scenario 6: reset mid-frame with a pending value that must never show.
    load(16'h0042, 4'b0001);
    #2 RST = 1'b1;
    #1;
    chk("s6_an", {28'd0, AN}, 32'hF);
    chk("s6_seg", {25'd0, seg}, 32'h7F);
    chk("s6_dp", {31'd0, DP}, 32'd1);
    chk("s6_frame", {31'd0, FRAME}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (FRAME !== 1'b1 && k < 40);
    chk("s6_first_commit", k, 32'd16);
    repeat (2) @(negedge CLK);
    check_digits("s6", vzero);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
